// File: rtl/bytes_screen_rx.sv
// bytes_screen_rx
//   Receive-side decoder for the bytes-screen UART byte stream.
//   A frame is "WAVWID" + 3-byte width, "OSCIDX" + 4 x 3-byte oscillator
//   indices, "WAVDAT" + 2 bytes per sample. The decoded width and indices are
//   committed to the outputs, and each sample is written out as a one-cycle
//   memory write strobe with its index as the address.
//
// Ports
//   clk_in           system clock
//   rst_n_in         asynchronous active-low reset
//   rx_valid_in      one-cycle strobe, rx_byte_in holds a new byte
//   rx_byte_in       received byte
//   wave_width_out   last accepted wave width
//   osc_indices_out  last accepted oscillator indices [0..3]
//   sample_we_out    one-cycle sample write strobe
//   sample_addr_out  sample index 0..width-1
//   sample_data_out  sample value
//   frame_done_out   one-cycle pulse, full frame received
//   err_sync_out     one-cycle pulse, header mismatch or width too large
//   err_timeout_out  one-cycle pulse, inter-byte gap too long inside a frame
//   busy_out         high whenever the decoder is not hunting for a header
module bytes_screen_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 208_340,
  parameter int unsigned MAX_WIDTH      = 262_143
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rx_valid_in,
  input  logic [7:0]       rx_byte_in,
  output logic [17:0]      wave_width_out,
  output logic [3:0][17:0] osc_indices_out,
  output logic             sample_we_out,
  output logic [17:0]      sample_addr_out,
  output logic [15:0]      sample_data_out,
  output logic             frame_done_out,
  output logic             err_sync_out,
  output logic             err_timeout_out,
  output logic             busy_out
);

  localparam logic [2:0] ST_HUNT     = 3'd0;
  localparam logic [2:0] ST_WID_DATA = 3'd1;
  localparam logic [2:0] ST_OSC_HDR  = 3'd2;
  localparam logic [2:0] ST_OSC_DATA = 3'd3;
  localparam logic [2:0] ST_DAT_HDR  = 3'd4;
  localparam logic [2:0] ST_DAT_DATA = 3'd5;

  localparam logic [47:0] HDR_WAVWID = 48'h57_41_56_57_49_44;
  localparam logic [47:0] HDR_OSCIDX = 48'h4F_53_43_49_44_58;
  localparam logic [47:0] HDR_WAVDAT = 48'h57_41_56_44_41_54;

  // Timer is sized so TIMEOUT_CYCLES itself is representable.
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  function automatic logic [7:0] hdr_at(input logic [47:0] h, input logic [3:0] i);
    case (i)
      4'd0:    hdr_at = h[47:40];
      4'd1:    hdr_at = h[39:32];
      4'd2:    hdr_at = h[31:24];
      4'd3:    hdr_at = h[23:16];
      4'd4:    hdr_at = h[15:8];
      default: hdr_at = h[7:0];
    endcase
  endfunction

  logic [2:0]       state_reg;
  logic [3:0]       idx_reg;        // header match index / data byte index
  logic [9:0]       width_sh_reg;   // only the bits that survive into 18 bits
  logic [17:0]      count_reg;
  logic [7:0]       hi_reg;
  logic             have_hi_reg;
  logic             osc_commit_reg;
  logic [TW-1:0]    timer_reg;

  logic [47:0]      hdr;
  logic [7:0]       exp_byte;
  logic             hit;
  logic             last_hdr;
  logic [17:0]      width_full;
  logic [1:0]       osc_sel;
  logic [3:0][17:0] osc_cat;

  always_comb begin
    hdr = HDR_WAVWID;
    case (state_reg)
      ST_OSC_HDR: hdr = HDR_OSCIDX;
      ST_DAT_HDR: hdr = HDR_WAVDAT;
      default:    hdr = HDR_WAVWID;
    endcase
    exp_byte = hdr_at(hdr, idx_reg);
  end

  assign hit        = (rx_byte_in == exp_byte);
  assign last_hdr   = (idx_reg == 4'd5);
  // Upper 6 bits of the first width byte fall off the top of this 18-bit value.
  assign width_full = {width_sh_reg, rx_byte_in};
  assign busy_out   = (state_reg != ST_HUNT);

  always_comb begin
    osc_sel = 2'd3;
    case (idx_reg)
      4'd0, 4'd1, 4'd2: osc_sel = 2'd0;
      4'd3, 4'd4, 4'd5: osc_sel = 2'd1;
      4'd6, 4'd7, 4'd8: osc_sel = 2'd2;
      default:          osc_sel = 2'd3;
    endcase
  end

  // One shadow shift register per oscillator lane; only the lane selected by
  // the byte index shifts, so each ends up holding its own 3 bytes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_osc
    logic [17:0] sh_reg;
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        sh_reg <= '0;
      end else if (rx_valid_in && state_reg == ST_OSC_DATA && osc_sel == 2'(gi)) begin
        sh_reg <= {sh_reg[9:0], rx_byte_in};
      end
    end
    assign osc_cat[gi] = sh_reg;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg       <= ST_HUNT;
      idx_reg         <= '0;
      width_sh_reg    <= '0;
      count_reg       <= '0;
      hi_reg          <= '0;
      have_hi_reg     <= 1'b0;
      osc_commit_reg  <= 1'b0;
      timer_reg       <= '0;
      wave_width_out  <= '0;
      osc_indices_out <= '0;
      sample_we_out   <= 1'b0;
      sample_addr_out <= '0;
      sample_data_out <= '0;
      frame_done_out  <= 1'b0;
      err_sync_out    <= 1'b0;
      err_timeout_out <= 1'b0;
    end else begin
      sample_we_out   <= 1'b0;
      frame_done_out  <= 1'b0;
      err_sync_out    <= 1'b0;
      err_timeout_out <= 1'b0;
      osc_commit_reg  <= 1'b0;
      // The last lane shifts on the 12th byte edge, so all four indices are
      // published together one cycle later.
      if (osc_commit_reg) begin
        osc_indices_out <= osc_cat;
      end

      if (rx_valid_in) begin
        timer_reg <= '0;
        case (state_reg)
          ST_HUNT: begin
            if (hit) begin
              if (last_hdr) begin
                state_reg <= ST_WID_DATA;
                idx_reg   <= '0;
              end else begin
                idx_reg <= idx_reg + 4'd1;
              end
            end else begin
              // A stray 'W' may itself be the start of the header.
              idx_reg <= (rx_byte_in == 8'h57) ? 4'd1 : 4'd0;
            end
          end
          ST_WID_DATA: begin
            width_sh_reg <= width_full[9:0];
            if (idx_reg == 4'd2) begin
              idx_reg <= '0;
              if ({14'd0, width_full} > MAX_WIDTH) begin
                err_sync_out <= 1'b1;
                state_reg    <= ST_HUNT;
              end else begin
                wave_width_out <= width_full;
                state_reg      <= ST_OSC_HDR;
              end
            end else begin
              idx_reg <= idx_reg + 4'd1;
            end
          end
          ST_OSC_HDR, ST_DAT_HDR: begin
            if (!hit) begin
              // The offending byte is dropped, not re-examined as a 'W'.
              err_sync_out <= 1'b1;
              state_reg    <= ST_HUNT;
              idx_reg      <= '0;
            end else if (last_hdr) begin
              idx_reg <= '0;
              if (state_reg == ST_OSC_HDR) begin
                state_reg <= ST_OSC_DATA;
              end else if (wave_width_out == '0) begin
                frame_done_out <= 1'b1;
                state_reg      <= ST_HUNT;
              end else begin
                state_reg   <= ST_DAT_DATA;
                count_reg   <= '0;
                have_hi_reg <= 1'b0;
              end
            end else begin
              idx_reg <= idx_reg + 4'd1;
            end
          end
          ST_OSC_DATA: begin
            if (idx_reg == 4'd11) begin
              osc_commit_reg <= 1'b1;
              state_reg      <= ST_DAT_HDR;
              idx_reg        <= '0;
            end else begin
              idx_reg <= idx_reg + 4'd1;
            end
          end
          ST_DAT_DATA: begin
            if (!have_hi_reg) begin
              hi_reg      <= rx_byte_in;
              have_hi_reg <= 1'b1;
            end else begin
              have_hi_reg     <= 1'b0;
              sample_we_out   <= 1'b1;
              sample_addr_out <= count_reg;
              sample_data_out <= {hi_reg, rx_byte_in};
              count_reg       <= count_reg + 18'd1;
              if (count_reg == wave_width_out - 18'd1) begin
                frame_done_out <= 1'b1;
                state_reg      <= ST_HUNT;
              end
            end
          end
          default: begin
            state_reg <= ST_HUNT;
            idx_reg   <= '0;
          end
        endcase
      end else if (state_reg != ST_HUNT) begin
        // Fires on the edge where the idle count would reach TIMEOUT_CYCLES.
        if (timer_reg == TO_LAST) begin
          err_timeout_out <= 1'b1;
          state_reg       <= ST_HUNT;
          idx_reg         <= '0;
          timer_reg       <= '0;
        end else begin
          timer_reg <= timer_reg + TW'(1);
        end
      end else begin
        timer_reg <= '0;
      end
    end
  end

endmodule
